// File: rtl/vm_multi_stock_if.sv
// rtl/vm_multi_stock_if.sv - front-end request and transaction-burst bundle for vm_multi_stock
interface vm_multi_stock_if #(
  parameter int N_ITEMS = 6,
  parameter int PRICE_W = 5,
  parameter int COIN_W  = 6,
  parameter int CNT_W   = 6,
  parameter int RES_W   = 4,
  parameter int IDX_W   = $clog2(N_ITEMS + 1)
);
  logic               in_price_valid;
  logic [PRICE_W-1:0] in_price;
  logic [PRICE_W-1:0] in_stock;
  logic               in_coin_valid;
  logic [COIN_W-1:0]  in_coin;
  logic [IDX_W-1:0]   in_buy_item;
  logic               in_refund_coin;
  logic               out_busy;
  logic               out_valid;
  logic [RES_W-1:0]   out_result;
  logic [CNT_W-1:0]   out_num;
  logic [1:0]         out_err;

  modport master (
    output in_price_valid, in_price, in_stock, in_coin_valid, in_coin,
           in_buy_item, in_refund_coin,
    input  out_busy, out_valid, out_result, out_num, out_err
  );

  modport slave (
    input  in_price_valid, in_price, in_stock, in_coin_valid, in_coin,
           in_buy_item, in_refund_coin,
    output out_busy, out_valid, out_result, out_num, out_err
  );
endinterface

// File: rtl/vm_multi_stock.sv
// rtl/vm_multi_stock.sv - multi-item vending controller with stock limits and serial result burst
// One buy/refund per burst; change is latched at request time and broken down greedily per beat.
module vm_multi_stock #(
  parameter int N_ITEMS = 6,
  parameter int PRICE_W = 5,
  parameter int COIN_W  = 6,
  parameter int MONEY_W = 9,
  parameter int CNT_W   = 6,
  parameter int RES_W   = 4,
  parameter int IDX_W   = $clog2(N_ITEMS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  vm_multi_stock_if.slave bus
);
  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MONEY_W-1:0] balance_q, balance_d;
  logic [PRICE_W-1:0] price_q [N_ITEMS];
  logic [PRICE_W-1:0] price_d [N_ITEMS];
  logic [PRICE_W-1:0] stock_q [N_ITEMS];
  logic [PRICE_W-1:0] stock_d [N_ITEMS];
  logic [CNT_W-1:0]   sold_q  [N_ITEMS];
  logic [CNT_W-1:0]   sold_d  [N_ITEMS];
  logic [IDX_W-1:0]   item_q, item_d;
  logic [1:0]         err_q, err_d;
  logic [MONEY_W-1:0] change_q, change_d;
  logic               pay_q, pay_d;

  logic [MONEY_W:0]   coin_sum;
  logic [IDX_W-1:0]   buy_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      idx_q     <= '0;
      balance_q <= '0;
      item_q    <= '0;
      err_q     <= '0;
      change_q  <= '0;
      pay_q     <= 1'b0;
      for (int k = 0; k < N_ITEMS; k++) begin
        price_q[k] <= '0;
        stock_q[k] <= '0;
        sold_q[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      balance_q <= balance_d;
      item_q    <= item_d;
      err_q     <= err_d;
      change_q  <= change_d;
      pay_q     <= pay_d;
      price_q   <= price_d;
      stock_q   <= stock_d;
      sold_q    <= sold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    balance_d = balance_q;
    item_d    = item_q;
    err_d     = err_q;
    change_d  = change_q;
    pay_d     = pay_q;
    price_d   = price_q;
    stock_d   = stock_q;
    sold_d    = sold_q;
    coin_sum  = {1'b0, balance_q} + (MONEY_W+1)'(bus.in_coin);
    buy_idx   = bus.in_buy_item - IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.in_price_valid) begin
          price_d[idx_q] = bus.in_price;
          stock_d[idx_q] = bus.in_stock;
          idx_d = (idx_q == IDX_W'(N_ITEMS - 1)) ? '0 : idx_q + IDX_W'(1);
          for (int k = 0; k < N_ITEMS; k++) sold_d[k] = '0;
        end else if (bus.in_coin_valid) begin
          balance_d = coin_sum[MONEY_W] ? '1 : coin_sum[MONEY_W-1:0];
        end else if (bus.in_buy_item != '0) begin
          state_d  = BURST;
          beat_d   = '0;
          item_d   = '0;
          change_d = '0;
          pay_d    = 1'b0;
          if (bus.in_buy_item > IDX_W'(N_ITEMS)) begin
            err_d = 2'd3;
          end else if (stock_q[buy_idx] == '0) begin
            err_d = 2'd2;
          end else if (balance_q < MONEY_W'(price_q[buy_idx])) begin
            err_d = 2'd1;
          end else begin
            err_d    = 2'd0;
            item_d   = bus.in_buy_item;
            change_d = balance_q - MONEY_W'(price_q[buy_idx]);
            pay_d    = 1'b1;
            stock_d[buy_idx] = stock_q[buy_idx] - PRICE_W'(1);
            if (sold_q[buy_idx] != '1) sold_d[buy_idx] = sold_q[buy_idx] + CNT_W'(1);
          end
        end else if (bus.in_refund_coin) begin
          state_d  = BURST;
          beat_d   = '0;
          item_d   = '0;
          err_d    = 2'd0;
          change_d = balance_q;
          pay_d    = 1'b1;
        end
      end
      BURST: begin
        if (beat_q == IDX_W'(N_ITEMS - 1)) begin
          state_d = IDLE;
          beat_d  = '0;
          // Paid-out change empties the balance; a rejected buy keeps it.
          if (pay_q) balance_d = '0;
        end else begin
          beat_d = beat_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [MONEY_W-1:0] rem50, rem20, rem10;
  logic [RES_W-1:0]   cnt50, cnt20, cnt10, cnt5, cnt1;

  always_comb begin
    cnt50 = RES_W'(change_q / MONEY_W'(50));
    rem50 = change_q % MONEY_W'(50);
    cnt20 = RES_W'(rem50 / MONEY_W'(20));
    rem20 = rem50 % MONEY_W'(20);
    cnt10 = RES_W'(rem20 / MONEY_W'(10));
    rem10 = rem20 % MONEY_W'(10);
    cnt5  = RES_W'(rem10 / MONEY_W'(5));
    cnt1  = RES_W'(rem10 % MONEY_W'(5));
  end

  always_comb begin
    bus.out_busy   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_result = '0;
    bus.out_num    = '0;
    bus.out_err    = '0;
    if (state_q == BURST) begin
      bus.out_busy  = 1'b1;
      bus.out_valid = 1'b1;
      bus.out_num   = sold_q[beat_q];
      case (beat_q)
        IDX_W'(0): begin
          bus.out_result = RES_W'(item_q);
          bus.out_err    = err_q;
        end
        IDX_W'(1): bus.out_result = cnt50;
        IDX_W'(2): bus.out_result = cnt20;
        IDX_W'(3): bus.out_result = cnt10;
        IDX_W'(4): bus.out_result = cnt5;
        IDX_W'(5): bus.out_result = cnt1;
        default:   bus.out_result = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_vm_multi_stock.sv
// tb/tb_vm_multi_stock.sv - scoreboard bench for vm_multi_stock with hand-computed bursts
module tb_vm_multi_stock;
  localparam int N_ITEMS = 6;
  localparam int IDX_W   = $clog2(N_ITEMS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vm_multi_stock_if #(.N_ITEMS(N_ITEMS)) bus ();

  vm_multi_stock #(.N_ITEMS(N_ITEMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int res;
    int num;
    int err;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (bus.out_valid) begin
      chk("busy_with_valid", int'(bus.out_busy), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_result", int'(bus.out_result), e.res);
        chk("beat_num", int'(bus.out_num), e.num);
        chk("beat_err", int'(bus.out_err), e.err);
      end
    end else begin
      chk("idle_outputs", int'(bus.out_busy) + int'(bus.out_result) + int'(bus.out_num)
          + int'(bus.out_err), 0);
    end
  end

  task automatic push_burst(input int code, input int err,
                            input int c50, input int c20, input int c10, input int c5, input int c1,
                            input int s1, input int s2, input int s3, input int s4, input int s5,
                            input int s6);
    int res [6];
    int num [6];
    res = '{code, c50, c20, c10, c5, c1};
    num = '{s1, s2, s3, s4, s5, s6};
    for (int k = 0; k < 6; k++) exp_q.push_back('{res: res[k], num: num[k], err: (k == 0) ? err : 0});
  endtask

  task automatic load(input int price, input int stock);
    bus.in_price_valid = 1'b1;
    bus.in_price = 5'(price);
    bus.in_stock = 5'(stock);
    @(negedge clk);
    bus.in_price_valid = 1'b0;
  endtask

  task automatic coin(input int value);
    bus.in_coin_valid = 1'b1;
    bus.in_coin = 6'(value);
    @(negedge clk);
    bus.in_coin_valid = 1'b0;
  endtask

  task automatic request(input int item, input bit refund, input bit pulse_coin, input bit cut);
    int busy_cnt;
    bus.in_buy_item = IDX_W'(item);
    bus.in_refund_coin = refund;
    @(negedge clk);
    bus.in_buy_item = '0;
    bus.in_refund_coin = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.out_busy) break;
      busy_cnt++;
      if (cut && c == 3) begin
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_cut_busy", int'(bus.out_busy), 0);
        chk("rst_cut_valid", int'(bus.out_valid), 0);
        chk("rst_cut_result", int'(bus.out_result), 0);
        chk("rst_cut_num", int'(bus.out_num), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cut_no_beats", int'(bus.out_valid), 0);
        return;
      end
      if (pulse_coin && c == 2) begin
        bus.in_coin_valid = 1'b1;
        bus.in_coin = 6'd20;
      end
      if (pulse_coin && c == 3) bus.in_coin_valid = 1'b0;
      @(negedge clk);
    end
    chk("busy_len", busy_cnt, 6);
  endtask

  initial begin
    bus.in_price_valid = 1'b0;
    bus.in_price = '0;
    bus.in_stock = '0;
    bus.in_coin_valid = 1'b0;
    bus.in_coin = '0;
    bus.in_buy_item = '0;
    bus.in_refund_coin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.out_busy), 0);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_result", int'(bus.out_result), 0);
    chk("reset_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // prices 1..6, stock 2 each; 73 in, buy item 3 -> change 70
    for (int p = 1; p <= 6; p++) load(p, 2);
    coin(50); coin(20); coin(3);
    push_burst(3, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    request(3, 0, 0, 0);

    // balance 2, item 5 too expensive; refund returns the 2
    coin(2);
    push_burst(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    request(5, 0, 0, 0);
    push_burst(0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    request(0, 1, 0, 0);

    // item 1 with stock 1: first buy change 9, second out of stock
    load(1, 1);
    for (int p = 2; p <= 6; p++) load(p, 2);
    coin(10);
    push_burst(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);
    request(1, 0, 0, 0);
    coin(10);
    push_burst(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    request(1, 0, 0, 0);

    // item 7 is out of range; coin during burst must be dropped
    push_burst(0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    request(7, 0, 1, 0);
    push_burst(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    request(0, 1, 0, 0);

    // load and buy in the same cycle: only the load (price 7, stock 3 at index 0)
    bus.in_buy_item = IDX_W'(2);
    load(7, 3);
    bus.in_buy_item = '0;
    for (int c = 0; c < 3; c++) begin
      chk("no_burst_on_load", int'(bus.out_busy), 0);
      @(negedge clk);
    end
    coin(7);
    push_burst(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    request(1, 0, 0, 0);

    // reset on beat 3 of a refund, then everything starts from zero
    coin(5);
    push_burst(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    request(0, 1, 0, 1);
    push_burst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    request(0, 1, 0, 0);
    push_burst(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    request(1, 0, 0, 0);

    // 11 x 50 saturates at 511 = 10x50 + 1x10 + 1x1
    for (int n = 0; n < 11; n++) coin(50);
    push_burst(0, 0, 10, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    request(0, 1, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
